voter_auth_gate: RTL and testbench
==================================

Name: voter_auth_gate

Overview:
- Upstream stage of voting_machine: collects a voter's 4-digit BCD password from the keypad one digit at a time and compares it with the valid password.
- On a match, accepts exactly one candidate button press and emits a single-cycle one-hot vote pulse to the candidate counters.
- Enforces one vote per authentication, a vote-window timeout, and lockout after repeated password failures.

Parameters:
- DIGITS, 4, number of BCD digits per password.
- MAX_TRIES, 3, consecutive failed checks before lockout (1..7).
- VOTE_TIMEOUT, 200, cycles allowed in VOTE before the ballot is abandoned (1..65535).

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  synchronous active-low reset.
- digit_valid  in  1  one-cycle strobe qualifying digit.
- digit  in  4  BCD keypad digit; first digit entered maps to A1.
- valid_pw  in  4*DIGITS  valid password, B1 in the MSB nibble; sampled only in CHECK.
- clear  in  1  abort the current entry or ballot.
- btn  in  4  candidate buttons A..D, level-sensitive, bit0 = A.
- admin_unlock  in  1  leaves LOCKED.
- vote_pulse  out  4  one-hot, one cycle wide, one bit per cast vote.
- match  out  1  high while a ballot is open (VOTE or RELEASE).
- locked  out  1  high in LOCKED.
- fail_cnt  out  3  consecutive failures.
- busy  out  1  high in any state except IDLE.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, vote_pulse=0, match=0, locked=0, fail_cnt=0, busy=0; the digit shift register, digit count, error flag and timer are all 0.
- Reset mid-ballot discards the ballot; no vote_pulse is emitted.
- IDLE:
  - Each digit_valid shifts digit into the register and increments the digit count.
  - A digit > 9 sets a sticky err flag.
  - When the DIGITS-th digit is accepted, go to CHECK on the next cycle.
  - clear resets the count and err flag; clear has priority over a same-cycle digit_valid.
- CHECK (exactly 1 cycle):
  - Pass if err==0 and the register equals valid_pw → VOTE. match rises on the cycle after CHECK: 2 cycles after the last digit strobe.
  - Fail: fail_cnt+1. If the new value equals MAX_TRIES → LOCKED, otherwise → IDLE.
  - Digit register, count and err are cleared on exit in both cases.
- VOTE:
  - The timer counts cycles spent in VOTE.
  - Buttons are armed only after btn==0 has been sampled at least once in VOTE, so a button held over from the previous voter never votes.
  - When armed and btn is exactly one-hot: vote_pulse=btn for the next cycle only, fail_cnt→0, state → RELEASE.
  - When btn has zero or ≥2 bits set: no vote, stay in VOTE.
  - timer reaching VOTE_TIMEOUT, or clear → IDLE, no vote, fail_cnt unchanged. clear has priority over a same-cycle valid press.
  - digit_valid is ignored.
- RELEASE: wait for btn==0, then → IDLE. Further presses are ignored; one vote per authentication.
- LOCKED:
  - All inputs are ignored except admin_unlock.
  - admin_unlock → IDLE with fail_cnt=0.
- digit_valid in CHECK, VOTE, RELEASE or LOCKED is dropped; it is not buffered.
- fail_cnt saturates at MAX_TRIES.
- vote_pulse is never multi-hot and never asserted outside the cycle after a RELEASE entry.

Test Plan:
- Password 2,9,8,7 vs valid_pw 0x2987:
  - match=1 two cycles after the 4th strobe.
  - btn=0000 then 0001 → vote_pulse=0001 for exactly one cycle.
  - Holding btn for 10 cycles gives no second pulse; release → IDLE.
- Entry 8,4,2,1 vs 0x8240: fail_cnt=1, match stays 0, state IDLE, no vote_pulse.
- Three consecutive wrong entries:
  - locked=1 after the 3rd CHECK; a subsequent correct entry is ignored.
  - admin_unlock → locked=0, fail_cnt=0.
  - Then a correct entry with press of C → vote_pulse=0100.
- Correct entry while btn=1000 already held:
  - No vote while held.
  - Release then press A → vote_pulse=0001.
  - btn=0011 → no pulse.
- Correct entry with no press for VOTE_TIMEOUT cycles: match falls, state IDLE, no pulse. Repeat with clear after 5 cycles: same result.
- Mid-ballot and entry corner cases:
  - rst_n=0 with match=1 → all outputs 0 on the next edge, no pulse.
  - Digit 0xA in an otherwise correct entry → CHECK fails, fail_cnt increments.

Source files
------------

// File: rtl/voter_auth_gate_if.sv
// Keypad/ballot bundle between the voter-facing front end and voter_auth_gate.
// master drives keypad, buttons and password; slave is the gate itself.
interface voter_auth_gate_if #(
  parameter int DIGITS = 4
);
  logic                  digit_valid;
  logic [3:0]            digit;
  logic [4*DIGITS-1:0]   valid_pw;
  logic                  clear;
  logic [3:0]            btn;
  logic                  admin_unlock;
  logic [3:0]            vote_pulse;
  logic                  match;
  logic                  locked;
  logic [2:0]            fail_cnt;
  logic                  busy;

  modport master (
    output digit_valid, digit, valid_pw, clear, btn, admin_unlock,
    input  vote_pulse, match, locked, fail_cnt, busy
  );

  modport slave (
    input  digit_valid, digit, valid_pw, clear, btn, admin_unlock,
    output vote_pulse, match, locked, fail_cnt, busy
  );
endinterface

// File: rtl/voter_auth_gate.sv
// Password gate in front of the vote counters: BCD entry, compare, one vote per
// authentication, vote-window timeout and lockout after repeated failures.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | collecting keypad digits
// CHECK   | one cycle: compare entry with valid_pw, count failures
// VOTE    | ballot open, waiting for an armed one-hot button press
// RELEASE | vote cast, waiting for all buttons to be released
// LOCKED  | too many failures, only admin_unlock is honoured
module voter_auth_gate #(
  parameter int DIGITS       = 4,
  parameter int MAX_TRIES    = 3,
  parameter int VOTE_TIMEOUT = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  voter_auth_gate_if.slave  bus
);

  localparam int PW_W  = 4 * DIGITS;
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam int TMR_W = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_VOTE    = 3'd2,
    S_RELEASE = 3'd3,
    S_LOCKED  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [PW_W-1:0]    pw_q, pw_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               armed_q, armed_d;
  logic [2:0]         fail_q, fail_d;
  logic [3:0]         vote_q, vote_d;
  logic               match_q, locked_q, busy_q;

  logic               btn_onehot;
  logic               pw_ok;
  logic [2:0]         fail_inc;

  assign btn_onehot = (bus.btn != 4'd0) && ((bus.btn & (bus.btn - 4'd1)) == 4'd0);
  assign pw_ok      = !err_q && (pw_q == bus.valid_pw);
  assign fail_inc   = (fail_q >= 3'(MAX_TRIES)) ? fail_q : fail_q + 3'd1;

  always_comb begin
    state_d = state_q;
    pw_d    = pw_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    timer_d = timer_q;
    armed_d = armed_q;
    fail_d  = fail_q;
    vote_d  = 4'd0;

    case (state_q)
      S_IDLE: begin
        if (bus.clear) begin
          pw_d  = '0;
          cnt_d = '0;
          err_d = 1'b0;
        end else if (bus.digit_valid) begin
          // first digit ends up in the MSB nibble after DIGITS shifts
          pw_d  = {pw_q[PW_W-5:0], bus.digit};
          cnt_d = cnt_q + CNT_W'(1);
          if (bus.digit > 4'd9) err_d = 1'b1;
          if (cnt_q == CNT_W'(DIGITS - 1)) state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        pw_d    = '0;
        cnt_d   = '0;
        err_d   = 1'b0;
        armed_d = 1'b0;
        if (pw_ok) begin
          state_d = S_VOTE;
          timer_d = TMR_W'(VOTE_TIMEOUT - 1);
        end else begin
          fail_d  = fail_inc;
          state_d = (fail_inc == 3'(MAX_TRIES)) ? S_LOCKED : S_IDLE;
        end
      end

      S_VOTE: begin
        if (bus.clear) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else if (armed_q && btn_onehot) begin
          vote_d  = bus.btn;
          fail_d  = 3'd0;
          state_d = S_RELEASE;
          timer_d = '0;
        end else if (timer_q == '0) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
          // a button still held from the previous voter must be released first
          if (bus.btn == 4'd0) armed_d = 1'b1;
        end
      end

      S_RELEASE: begin
        armed_d = 1'b0;
        if (bus.btn == 4'd0) state_d = S_IDLE;
      end

      S_LOCKED: begin
        if (bus.admin_unlock) begin
          state_d = S_IDLE;
          fail_d  = 3'd0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pw_q     <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      timer_q  <= '0;
      armed_q  <= 1'b0;
      fail_q   <= 3'd0;
      vote_q   <= 4'd0;
      match_q  <= 1'b0;
      locked_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pw_q     <= pw_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      timer_q  <= timer_d;
      armed_q  <= armed_d;
      fail_q   <= fail_d;
      vote_q   <= vote_d;
      match_q  <= (state_d == S_VOTE) || (state_d == S_RELEASE);
      locked_q <= (state_d == S_LOCKED);
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign bus.vote_pulse = vote_q;
  assign bus.match      = match_q;
  assign bus.locked     = locked_q;
  assign bus.fail_cnt   = fail_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_voter_auth_gate.sv
// Self-checking bench for voter_auth_gate: table of password entries plus
// hand-written lockout, held-button, timeout, clear and reset sequences.
module tb_voter_auth_gate;

  localparam int VOTE_TIMEOUT = 200;

  logic clk;
  logic rst_n;

  voter_auth_gate_if #(.DIGITS(4)) bus ();

  voter_auth_gate #(
    .DIGITS(4),
    .MAX_TRIES(3),
    .VOTE_TIMEOUT(VOTE_TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [15:0] entry;
    logic [15:0] pw;
    logic [3:0]  press;
    logic        exp_match;
    logic [2:0]  exp_fail;
    logic        exp_locked;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_pw(input logic [15:0] pw);
    for (int i = 0; i < 4; i++) begin
      bus.digit       = pw[15-4*i -: 4];
      bus.digit_valid = 1'b1;
      cycle();
      bus.digit_valid = 1'b0;
    end
  endtask

  // cast one vote from an open ballot, hold the button, then release it
  task automatic do_vote(input logic [3:0] press);
    bus.btn = 4'd0;
    cycle();
    bus.btn = press;
    exp_q.push_back(press);
    cycle();
    repeat (10) cycle();
    bus.btn = 4'd0;
    cycle();
    chk("vote_done_busy", 32'(bus.busy), 32'd0);
    chk("vote_done_fail_cnt", 32'(bus.fail_cnt), 32'd0);
  endtask

  // scoreboard: every nonzero pulse must match the oldest expected press
  always @(negedge clk) begin
    if (bus.vote_pulse !== 4'd0) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL vote_pulse_unexpected: got %b, expected no pulse", bus.vote_pulse);
      end else begin
        chk("vote_pulse", 32'(bus.vote_pulse), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h2987, 16'h2987, 4'b0001, 1'b1, 3'd0, 1'b0};
    vecs[1] = '{16'h8421, 16'h8240, 4'b0000, 1'b0, 3'd1, 1'b0};
    vecs[2] = '{16'h2A87, 16'h2987, 4'b0000, 1'b0, 3'd2, 1'b0};
    vecs[3] = '{16'h1234, 16'h1234, 4'b1000, 1'b1, 3'd2, 1'b0};
    vecs[4] = '{16'h0000, 16'h9999, 4'b0000, 1'b0, 3'd1, 1'b0};
    vecs[5] = '{16'h9999, 16'h9999, 4'b0010, 1'b1, 3'd1, 1'b0};

    rst_n            = 1'b0;
    bus.digit_valid  = 1'b0;
    bus.digit        = 4'd0;
    bus.valid_pw     = 16'h0;
    bus.clear        = 1'b0;
    bus.btn          = 4'd0;
    bus.admin_unlock = 1'b0;
    repeat (2) cycle();
    chk("rst_vote_pulse", 32'(bus.vote_pulse), 32'd0);
    chk("rst_match", 32'(bus.match), 32'd0);
    chk("rst_locked", 32'(bus.locked), 32'd0);
    chk("rst_fail_cnt", 32'(bus.fail_cnt), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    cycle();

    for (int i = 0; i < 6; i++) begin
      bus.valid_pw = vecs[i].pw;
      enter_pw(vecs[i].entry);
      chk("check_cycle_match", 32'(bus.match), 32'd0);
      cycle();
      chk("vec_match", 32'(bus.match), 32'(vecs[i].exp_match));
      chk("vec_fail_cnt", 32'(bus.fail_cnt), 32'(vecs[i].exp_fail));
      chk("vec_locked", 32'(bus.locked), 32'(vecs[i].exp_locked));
      if (vecs[i].exp_match) do_vote(vecs[i].press);
      else chk("vec_fail_busy", 32'(bus.busy), 32'd0);
    end

    // lockout after three consecutive failures
    bus.valid_pw = 16'h2987;
    for (int i = 1; i <= 3; i++) begin
      enter_pw(16'h1111);
      cycle();
      chk("lock_fail_cnt", 32'(bus.fail_cnt), 32'(i));
    end
    chk("lock_locked", 32'(bus.locked), 32'd1);
    enter_pw(16'h2987);
    cycle();
    chk("lock_ignore_match", 32'(bus.match), 32'd0);
    chk("lock_still_locked", 32'(bus.locked), 32'd1);
    bus.admin_unlock = 1'b1;
    cycle();
    bus.admin_unlock = 1'b0;
    chk("unlock_locked", 32'(bus.locked), 32'd0);
    chk("unlock_fail_cnt", 32'(bus.fail_cnt), 32'd0);
    enter_pw(16'h2987);
    cycle();
    chk("unlock_match", 32'(bus.match), 32'd1);
    do_vote(4'b0100);

    // button held over from a previous voter never votes
    bus.btn = 4'b1000;
    enter_pw(16'h2987);
    cycle();
    chk("held_match", 32'(bus.match), 32'd1);
    repeat (5) cycle();
    bus.btn = 4'd0;
    cycle();
    bus.btn = 4'b0011;
    repeat (5) cycle();
    chk("multi_hot_still_vote", 32'(bus.match), 32'd1);
    bus.btn = 4'b0001;
    exp_q.push_back(4'b0001);
    cycle();
    bus.btn = 4'd0;
    cycle();
    chk("held_done_busy", 32'(bus.busy), 32'd0);

    // vote window expires with no press
    enter_pw(16'h2987);
    cycle();
    chk("tmo_match", 32'(bus.match), 32'd1);
    repeat (VOTE_TIMEOUT - 1) cycle();
    chk("tmo_last_cycle_match", 32'(bus.match), 32'd1);
    cycle();
    chk("tmo_match_fall", 32'(bus.match), 32'd0);
    chk("tmo_busy", 32'(bus.busy), 32'd0);

    // clear abandons the ballot
    enter_pw(16'h2987);
    cycle();
    repeat (5) cycle();
    bus.clear = 1'b1;
    cycle();
    bus.clear = 1'b0;
    chk("clr_match", 32'(bus.match), 32'd0);
    chk("clr_busy", 32'(bus.busy), 32'd0);

    // clear wins over a same-cycle digit strobe in IDLE
    bus.digit = 4'd2; bus.digit_valid = 1'b1; cycle();
    bus.digit = 4'd9; cycle();
    bus.digit = 4'd8; bus.clear = 1'b1; cycle();
    bus.clear = 1'b0; bus.digit_valid = 1'b0;
    enter_pw(16'h2987);
    cycle();
    chk("clr_prio_match", 32'(bus.match), 32'd1);
    bus.clear = 1'b1;
    cycle();
    bus.clear = 1'b0;

    // reset during an open ballot
    enter_pw(16'h5555);
    cycle();
    enter_pw(16'h2987);
    cycle();
    chk("mid_rst_pre_match", 32'(bus.match), 32'd1);
    chk("mid_rst_pre_fail", 32'(bus.fail_cnt), 32'd1);
    rst_n = 1'b0;
    cycle();
    chk("mid_rst_match", 32'(bus.match), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_fail", 32'(bus.fail_cnt), 32'd0);
    chk("mid_rst_pulse", 32'(bus.vote_pulse), 32'd0);
    rst_n = 1'b1;
    repeat (2) cycle();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
